// File: rtl/accu_half_sched.sv
// accu_half_sched: round-robin scheduler that time-shares one float16
// accumulator datapath among NREQ requesters. One whole vector is granted
// at a time. A tag pipe follows each vector through the datapath latency so
// that its sum can be captured when it appears on acc_r.
// Optional feature macro: ACCU_SCHED_WDOG_EN. It adds a stall watchdog and
// the res_abort output.
module accu_half_sched #(
  parameter int NREQ        = 4,
  parameter int ACC_LATENCY = 3,
  parameter int LEN_W       = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [16*NREQ-1:0]      req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic [15:0]             acc_x,
  output logic                    acc_n,
  input  logic [15:0]             acc_r,
  output logic                    res_valid,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic [15:0]             res_data,
  output logic [LEN_W-1:0]        res_len,
`ifdef ACCU_SCHED_WDOG_EN
  output logic                    res_abort,
`endif
  output logic                    busy
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int DEPTH = ACC_LATENCY + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic             last;
`ifdef ACCU_SCHED_WDOG_EN
    logic             abort;
`endif
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } tag_t;

  // Reject parameter values the scheduler is not built for.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("accu_half_sched: NREQ must be in 2..8");
  end
  if (ACC_LATENCY < 1 || WDOG_CYCLES < 1) begin : g_bad_latency
    $error("accu_half_sched: ACC_LATENCY and WDOG_CYCLES must be positive");
  end

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        grant_q, grant_d;
  logic [ID_W-1:0]        rr_q, rr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [15:0]            acc_x_q, acc_x_d;
  logic                   acc_n_q, acc_n_d;
  tag_t [DEPTH-1:0]       pipe_q, pipe_d;
  tag_t                   push_tag;
  logic                   res_valid_q, res_valid_d;
  logic [ID_W-1:0]        res_id_q, res_id_d;
  logic [15:0]            res_data_q, res_data_d;
  logic [LEN_W-1:0]       res_len_q, res_len_d;

  logic [ID_W-1:0]        pick;
  logic                   found;
  int                     idx;
  logic                   gnt_valid;
  logic                   gnt_last;
  logic [15:0]            gnt_data;
  logic [ID_W-1:0]        next_ptr;
  logic [LEN_W-1:0]       len_inc;

`ifdef ACCU_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0]      wdog_q, wdog_d;
  logic                   res_abort_q, res_abort_d;
`endif

  // Pick the first valid requester at or after the round-robin pointer.
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
  end

  // Select the granted requester's inputs and drive its ready bit only.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == ID_W'(i)) begin
        gnt_valid    = req_valid[i];
        gnt_last     = req_last[i];
        gnt_data     = req_data[16*i +: 16];
        req_ready[i] = (state_q == BURST);
      end
    end
  end

  assign next_ptr = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + ID_W'(1);
  assign len_inc  = (len_q == LEN_MAX) ? len_q : len_q + LEN_W'(1);

  // Grant FSM: lock a requester for its whole vector and feed the datapath,
  // adding zeros on every cycle without a handshake.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    len_d    = len_q;
    acc_x_d  = '0;
    acc_n_d  = 1'b0;
    push_tag = '0;
`ifdef ACCU_SCHED_WDOG_EN
    wdog_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          len_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (gnt_valid) begin
          acc_x_d = gnt_data;
          acc_n_d = (len_q == '0);
          len_d   = len_inc;
          if (gnt_last) begin
            push_tag.last = 1'b1;
            push_tag.id   = grant_q;
            push_tag.len  = len_inc;
            state_d       = IDLE;
            rr_d          = next_ptr;
          end
        end
`ifdef ACCU_SCHED_WDOG_EN
        else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          // A vector with no accepted element still restarts the sum, so
          // the aborted result reads as zero rather than a stale total.
          acc_n_d        = (len_q == '0);
          push_tag.last  = 1'b1;
          push_tag.abort = 1'b1;
          push_tag.id    = grant_q;
          push_tag.len   = len_q;
          state_d        = IDLE;
          rr_d           = next_ptr;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag pipe advances every cycle, in step with the datapath.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = push_tag;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Capture the sum when a closing tag leaves the pipe.
  always_comb begin
    res_valid_d = pipe_q[DEPTH-1].last;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    res_len_d   = res_len_q;
`ifdef ACCU_SCHED_WDOG_EN
    res_abort_d = 1'b0;
`endif
    if (pipe_q[DEPTH-1].last) begin
      res_id_d    = pipe_q[DEPTH-1].id;
      res_data_d  = acc_r;
      res_len_d   = pipe_q[DEPTH-1].len;
`ifdef ACCU_SCHED_WDOG_EN
      res_abort_d = pipe_q[DEPTH-1].abort;
`endif
    end
  end

  // Busy while a vector is granted or a closing tag is still in flight.
  always_comb begin
    busy = (state_q == BURST);
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_q[i].last) busy = 1'b1;
    end
  end

  // State registers; reset drops any partial vector and in-flight results.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      len_q       <= '0;
      acc_x_q     <= '0;
      acc_n_q     <= 1'b0;
      pipe_q      <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      res_len_q   <= '0;
`ifdef ACCU_SCHED_WDOG_EN
      wdog_q      <= '0;
      res_abort_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      len_q       <= len_d;
      acc_x_q     <= acc_x_d;
      acc_n_q     <= acc_n_d;
      pipe_q      <= pipe_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
      res_len_q   <= res_len_d;
`ifdef ACCU_SCHED_WDOG_EN
      wdog_q      <= wdog_d;
      res_abort_q <= res_abort_d;
`endif
    end
  end

  assign acc_x     = acc_x_q;
  assign acc_n     = acc_n_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;
  assign res_len   = res_len_q;
`ifdef ACCU_SCHED_WDOG_EN
  assign res_abort = res_abort_q;
`endif

endmodule

// File: tb/tb_accu_half_sched.sv
// tb_accu_half_sched: drives vectors from several requesters, stands in for
// the accumulator datapath, and checks each result against a scoreboard.
module tb_accu_half_sched;

  localparam int NREQ        = 4;
  localparam int ACC_LATENCY = 3;
  localparam int LEN_W       = 8;
  localparam int WDOG_CYCLES = 64;
  localparam int TIMEOUT     = 300;

  logic                    clock = 1'b0;
  logic                    resetn = 1'b0;
  logic [NREQ-1:0]         req_valid;
  logic [16*NREQ-1:0]      req_data;
  logic [NREQ-1:0]         req_last;
  logic [NREQ-1:0]         req_ready;
  logic [15:0]             acc_x;
  logic                    acc_n;
  logic [15:0]             acc_r;
  logic                    res_valid;
  logic [$clog2(NREQ)-1:0] res_id;
  logic [15:0]             res_data;
  logic [LEN_W-1:0]        res_len;
  logic                    busy;
`ifdef ACCU_SCHED_WDOG_EN
  logic                    res_abort;
`endif

  logic        v_arr [NREQ];
  logic        l_arr [NREQ];
  logic [15:0] d_arr [NREQ];

  typedef struct {
    int          id;
    logic [15:0] data;
    int          len;
    int          cyc;
    bit          abort;
  } exp_t;

  exp_t sb_q [$];
  exp_t mon_e;
  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  int   cyc_cnt    = 0;

  accu_half_sched #(
    .NREQ(NREQ), .ACC_LATENCY(ACC_LATENCY), .LEN_W(LEN_W), .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .acc_x(acc_x), .acc_n(acc_n), .acc_r(acc_r),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_len(res_len),
`ifdef ACCU_SCHED_WDOG_EN
    .res_abort(res_abort),
`endif
    .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = v_arr[i];
      req_last[i]          = l_arr[i];
      req_data[16*i +: 16] = d_arr[i];
    end
  end

  // float16 to fixed point with 10 fraction bits (normal numbers only)
  function automatic int fp2fix(input logic [15:0] h);
    int mag;
    int sh;
    if (h[14:10] == 5'd0) return 0;
    mag = 1024 + int'(h[9:0]);
    sh  = int'(h[14:10]) - 15;
    if (sh >= 0) mag = mag << sh;
    else         mag = mag >> (-sh);
    return h[15] ? -mag : mag;
  endfunction

  function automatic logic [15:0] fix2fp(input int v);
    int a;
    int p;
    int m;
    logic [4:0] e;
    if (v == 0) return 16'h0000;
    a = (v < 0) ? -v : v;
    p = 0;
    for (int b = 0; b < 31; b++) if (a[b]) p = b;
    e = 5'(p + 5);
    m = (p >= 10) ? (a >> (p - 10)) : (a << (10 - p));
    return {(v < 0), e, m[9:0]};
  endfunction

  // Accumulator datapath stand-in: sum on the sample edge, then two
  // output stages, giving r three edges after x/n are sampled.
  int          acc_fix;
  logic [15:0] r1, r2;
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_fix <= 0;
      r1      <= '0;
      r2      <= '0;
    end else begin
      acc_fix <= acc_n ? fp2fix(acc_x) : acc_fix + fp2fix(acc_x);
      r1      <= fix2fp(acc_fix);
      r2      <= r1;
    end
  end
  assign acc_r = r2;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
    end
  endtask

  task automatic checkResetState(input string where);
    checkOutput({where, ".req_ready"}, 32'(req_ready), 0);
    checkOutput({where, ".acc_x"},     32'(acc_x),     0);
    checkOutput({where, ".acc_n"},     32'(acc_n),     0);
    checkOutput({where, ".res_valid"}, 32'(res_valid), 0);
    checkOutput({where, ".res_id"},    32'(res_id),    0);
    checkOutput({where, ".res_data"},  32'(res_data),  0);
    checkOutput({where, ".res_len"},   32'(res_len),   0);
    checkOutput({where, ".busy"},      32'(busy),      0);
  endtask

  // Result monitor: every res_valid pulse must match the oldest expectation.
  always @(negedge clock) begin
    if (resetn && res_valid) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_result", 32'(res_valid), 0);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("res_id",   32'(res_id),   32'(mon_e.id));
        checkOutput("res_data", 32'(res_data), 32'(mon_e.data));
        checkOutput("res_len",  32'(res_len),  32'(mon_e.len));
        if (mon_e.cyc >= 0) checkOutput("res_latency", 32'(cyc_cnt), 32'(mon_e.cyc));
`ifdef ACCU_SCHED_WDOG_EN
        checkOutput("res_abort", 32'(res_abort), 32'(mon_e.abort));
`endif
      end
    end
  end

  // Send one vector from requester id, entered and left on a negedge.
  // hs_cyc returns the cycle of the final accepted element.
  task automatic applyStimulus(input int id, input int n,
                               input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                               input bit close_vec, input int stall_at, input int stall_len,
                               input logic [15:0] exp_data, input int exp_len, input bit do_push,
                               output int hs_cyc);
    logic [15:0] el [3];
    bit  got;
    int  waited;
    el[0] = e0; el[1] = e1; el[2] = e2;
    hs_cyc = -1;
    for (int k = 0; k < n; k++) begin
      v_arr[id] = 1'b1;
      d_arr[id] = el[k];
      l_arr[id] = close_vec && (k == n - 1);
      got = 1'b0;
      waited = 0;
      while (!got && waited < TIMEOUT) begin
        #1;
        if (req_ready[id]) begin
          got = 1'b1;
          hs_cyc = cyc_cnt;
        end
        @(negedge clock);
        if (!got) waited++;
      end
      v_arr[id] = 1'b0;
      l_arr[id] = 1'b0;
      if (!got) begin
        checkOutput($sformatf("hs_timeout_req%0d", id), 32'(got), 1);
        return;
      end
      checkOutput($sformatf("acc_x_req%0d", id), 32'(acc_x), 32'(el[k]));
      checkOutput($sformatf("acc_n_req%0d", id), 32'(acc_n), 32'(k == 0));
      if (close_vec && k == n - 1 && do_push)
        sb_q.push_back('{id: id, data: exp_data, len: exp_len, cyc: hs_cyc + ACC_LATENCY + 2, abort: 1'b0});
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clock);
          checkOutput("bubble_acc_x", 32'(acc_x), 0);
          checkOutput("bubble_busy", 32'(busy), 1);
        end
      end
    end
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < TIMEOUT) begin
      @(negedge clock);
      w++;
    end
    checkOutput("scoreboard_drain", 32'(sb_q.size()), 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int ha, hb;
    for (int i = 0; i < NREQ; i++) begin
      v_arr[i] = 1'b0;
      l_arr[i] = 1'b0;
      d_arr[i] = '0;
    end
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checkResetState("por");
    resetn = 1'b1;
    @(negedge clock);

    // 1.0 + 2.0 + 0.5 = 3.5 from requester 0
    applyStimulus(0, 3, 16'h3C00, 16'h4000, 16'h3800, 1, -1, 0, 16'h4300, 3, 1, ha);
    waitDrain();

    // Reset two cycles after a closing handshake drops the pending result
    applyStimulus(0, 1, 16'h3C00, 16'h0000, 16'h0000, 1, -1, 0, 16'h3C00, 1, 0, ha);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    checkResetState("mid_flight");
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    applyStimulus(3, 2, 16'h3800, 16'h3800, 16'h0000, 1, -1, 0, 16'h3C00, 2, 1, ha);
    waitDrain();

    // Requesters 1 and 3 together with the pointer at 0: 1 first, then 3
    fork
      applyStimulus(1, 2, 16'h3C00, 16'h3C00, 16'h0000, 1, -1, 0, 16'h4000, 2, 1, ha);
      applyStimulus(3, 2, 16'h4000, 16'h3800, 16'h0000, 1, -1, 0, 16'h4100, 2, 1, hb);
    join
    checkOutput("rr_order_1_before_3", 32'(ha < hb), 1);
    waitDrain();

    // After serving 1 the pointer sits at 2, so 2 wins over a new request from 1
    applyStimulus(1, 1, 16'h3C00, 16'h0000, 16'h0000, 1, -1, 0, 16'h3C00, 1, 1, ha);
    fork
      applyStimulus(1, 1, 16'h4000, 16'h0000, 16'h0000, 1, -1, 0, 16'h4000, 1, 1, ha);
      applyStimulus(2, 1, 16'h3800, 16'h0000, 16'h0000, 1, -1, 0, 16'h3800, 1, 1, hb);
    join
    checkOutput("rr_order_2_before_1", 32'(hb < ha), 1);
    waitDrain();

    // 1.5, seven stall cycles, then 1.5: zero-fill keeps the sum at 3.0
    applyStimulus(2, 2, 16'h3E00, 16'h3E00, 16'h0000, 1, 0, 7, 16'h4200, 2, 1, ha);
    waitDrain();

    // Back-to-back single-element vectors from requesters 0 and 1
    fork
      applyStimulus(0, 1, 16'h4000, 16'h0000, 16'h0000, 1, -1, 0, 16'h4000, 1, 1, ha);
      applyStimulus(1, 1, 16'hBC00, 16'h0000, 16'h0000, 1, -1, 0, 16'hBC00, 1, 1, hb);
    join
    checkOutput("b2b_gap", 32'(hb - ha), 2);
    waitDrain();

`ifdef ACCU_SCHED_WDOG_EN
    // Requester 0 goes silent after one element; the watchdog closes it
    applyStimulus(0, 1, 16'h3C00, 16'h0000, 16'h0000, 0, -1, 0, 16'h0000, 0, 0, ha);
    sb_q.push_back('{id: 0, data: 16'h3C00, len: 1, cyc: -1, abort: 1'b1});
    waitDrain();
`endif

    checkOutput("final_busy", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/accu_half_sched.md
Name: accu_half_sched

Overview:
- Round-robin scheduler that shares one half-precision accumulator datapath among NREQ requesters.
- The datapath converts float16 to 19-bit fixed, accumulates continuously, and returns a float16 sum. It has no enable input. Its n input restarts accumulation.
- Each requester streams a vector of float16 elements over valid/ready with a last flag.
- The scheduler locks the grant for a whole vector and drives the datapath x/n. It zero-fills idle cycles, tags in-flight vectors, and captures each vector's sum when it leaves the datapath pipeline.

Parameters:
- NREQ, 4: number of requesters (2..8).
- ACC_LATENCY, 3: datapath latency, from an x/n sample edge to r valid.
- LEN_W, 8: width of the element counter and of res_len.
- WDOG_CYCLES, 64: stall limit for the optional watchdog.

Ports:
- clock  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester element valid.
- req_data  in  16*NREQ  float16 element; requester i occupies bits [16i+15:16i].
- req_last  in  NREQ  element is the final one of its vector.
- req_ready  out  NREQ  element accepted when valid&ready.
- acc_x  out  16  float16 operand to the datapath (registered).
- acc_n  out  1  restart-accumulation strobe to the datapath (registered).
- acc_r  in  16  float16 accumulated result from the datapath.
- res_valid  out  1  single-cycle result strobe.
- res_id  out  $clog2(NREQ)  requester that owns the result.
- res_data  out  16  float16 vector sum.
- res_len  out  LEN_W  element count of the vector (saturating).
- busy  out  1  a vector is granted or a result is in flight.

Behaviour:
- Reset: clock and resetn as already decided (reset resetn, asynchronous, active-low; clock clock).
  - Reset values: req_ready=0, acc_x=16'h0000, acc_n=0, res_valid=0, res_id=0, res_data=0, res_len=0, busy=0.
  - Reset also clears the round-robin pointer to 0, clears the tag pipe and returns the FSM to IDLE.
  - Reset mid-vector or mid-flight drops the partial vector and all in-flight results; no res_valid is produced for them.
- FSM, IDLE:
  - If any req_valid is high, grant the first valid requester at or after rr_ptr, cyclically. Latch the grant and go to BURST.
  - No element is accepted in this cycle; req_ready=0.
- FSM, BURST:
  - req_ready[g]=1 for the granted requester only; all other req_ready bits are 0.
  - On a handshake: acc_x<=req_data[g] and acc_n<=first, where first=1 on the vector's first accepted element.
  - The element counter increments on each handshake and saturates at 2^LEN_W-1.
  - On a handshake with req_last[g]=1: push tag {last=1, id=g, len} and go to IDLE. Set rr_ptr=(g+1) mod NREQ.
  - This gives one bubble cycle between vectors.
- Bubble cycles (any cycle without a handshake): acc_x<=16'h0000 and acc_n<=0. This is mandatory because the datapath accumulates every cycle, so it must add zero on idle cycles.
- Tag pipe: a shift register of ACC_LATENCY+1 stages. A non-last handshake pushes a null tag.
- Result capture: when a last tag reaches the pipe end, register res_data<=acc_r, res_id and res_len, and pulse res_valid for one cycle.
  - Latency: a last-element handshake in cycle h gives res_valid in cycle h+ACC_LATENCY+2 (h+5 at the default).
- Back-to-back vectors are legal. The new vector's acc_n load happens on the same edge on which the datapath registers the previous sum, so no extra gap is needed.
- There is no result backpressure. The consumer must accept the res_valid pulse when it occurs.
- Requester deasserting valid mid-vector: the scheduler waits in BURST and inserts zero bubbles, which leave the sum unaffected.
- Single-element vector (first and last on the same handshake): acc_n=1, res_len=1.
- busy = (state==BURST) | (any tag in the pipe marked last).

Optional Feature:
- Macro: ACCU_SCHED_WDOG_EN.
- When defined: a counter runs in BURST while req_valid[g]=0 and clears on each handshake.
  - When it reaches WDOG_CYCLES, the scheduler force-closes the vector: it pushes a last tag, goes to IDLE and advances rr_ptr.
  - An extra output res_abort (1 bit, reset 0) is asserted alongside res_valid for that result.
- When undefined: no counter, no res_abort port, and BURST waits indefinitely.

Test Plan:
- Requester 0 sends 1.0 (3C00), 2.0 (4000), last 0.5 (3800): res_valid appears 5 cycles after the last handshake with res_data=4300 (3.5), res_id=0, res_len=3.
- Requesters 1 and 3 both valid from IDLE with rr_ptr=0: requester 1 is served first, then requester 3. A subsequent request from 1 while 2 is valid: requester 2 is served first.
- Requester 2 sends 1.5 (3E00), stalls 7 cycles, then last 1.5: res_data=4200 (3.0), confirming zero-fill during the stall.
- Two back-to-back single-element vectors, 2.0 then -1.0 (BC00), from different requesters: two results, 4000 then BC00, with no cross-contamination.
- resetn asserted 2 cycles after a last handshake: no res_valid; all outputs at reset values. A fresh vector afterwards sums correctly.
- With ACCU_SCHED_WDOG_EN and WDOG_CYCLES=64: requester 0 sends 1.0 then goes silent. After 64 stall cycles, res_valid is asserted with res_abort=1, res_data=3C00, res_len=1.
